// File: rtl/ras_rt_ckpt.sv
// Retire-side checkpoint queue for the fetch return address stack: holds each
// RAS-affecting branch's post-operation pointer until it retires or flushes.
module ras_rt_ckpt #(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3,
   parameter int PTR_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             alloc_vld_i,
   input  logic [PTR_W-1:0] alloc_ptr_i,
   output logic             alloc_rdy_o,
   output logic [IDX_W-1:0] alloc_tag_o,
   input  logic             retire_vld_i,
   input  logic             flush_rt_i,
   output logic [PTR_W-1:0] ras_ptr_rt_o,
   output logic             bob_vld_o,
   output logic [IDX_W:0]   count_o
);

   // Handshake: an allocation transfers on a cycle where alloc_vld_i and
   // alloc_rdy_o are both high; with alloc_rdy_o low the request is dropped
   // and the sender must hold it. Retire and flush have no back-pressure.

   logic [PTR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] mem_d [DEPTH];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic [PTR_W-1:0] arch_ptr_q, arch_ptr_d;

   logic empty;
   logic full;
   logic alloc_fire;
   logic retire_fire;

   assign empty       = (count_q == '0);
   assign full        = (count_q == (IDX_W+1)'(DEPTH));
   assign alloc_rdy_o = ~full & ~flush_rt_i;
   assign alloc_fire  = alloc_vld_i & alloc_rdy_o;
   assign retire_fire = retire_vld_i & ~empty & ~flush_rt_i;

   assign alloc_tag_o  = tail_q;
   assign ras_ptr_rt_o = empty ? arch_ptr_q : mem_q[head_q];
   assign bob_vld_o    = ~empty;
   assign count_o      = count_q;

   always_comb begin
      mem_d      = mem_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      arch_ptr_d = arch_ptr_q;
      if (flush_rt_i) begin
         // The flushed branch becomes the architectural pointer; everything
         // younger is discarded.
         if (!empty) begin
            arch_ptr_d = mem_q[head_q];
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_fire) begin
            mem_d[tail_q] = alloc_ptr_i;
            tail_d        = tail_q + IDX_W'(1);
         end
         if (retire_fire) begin
            arch_ptr_d = mem_q[head_q];
            head_d     = head_q + IDX_W'(1);
         end
         case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + (IDX_W+1)'(1);
            2'b01:   count_d = count_q - (IDX_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         arch_ptr_q <= '0;
      end else begin
         mem_q      <= mem_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         arch_ptr_q <= arch_ptr_d;
      end
   end

endmodule

// File: tb/tb_ras_rt_ckpt.sv
// Directed bench for ras_rt_ckpt: a vector table for the main sequences plus
// hand-written wrap-around and asynchronous-reset sequences.
module tb_ras_rt_ckpt;

   localparam int DEPTH = 8;
   localparam int IDX_W = 3;
   localparam int PTR_W = 4;
   localparam int NVEC  = 34;

   logic             clock;
   logic             reset_n;
   logic             alloc_vld_i;
   logic [PTR_W-1:0] alloc_ptr_i;
   logic             alloc_rdy_o;
   logic [IDX_W-1:0] alloc_tag_o;
   logic             retire_vld_i;
   logic             flush_rt_i;
   logic [PTR_W-1:0] ras_ptr_rt_o;
   logic             bob_vld_o;
   logic [IDX_W:0]   count_o;

   int checks;
   int failures;

   logic [PTR_W-1:0] exp_q[$];

   typedef struct {
      logic             av;
      logic [PTR_W-1:0] ap;
      logic             rv;
      logic             fl;
      logic             rdy;
      logic [IDX_W-1:0] tag;
      logic [PTR_W-1:0] rp;
      logic             bv;
      logic [IDX_W:0]   cnt;
   } vec_t;

   vec_t vecs[NVEC];

   ras_rt_ckpt #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PTR_W(PTR_W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .alloc_vld_i  (alloc_vld_i),
      .alloc_ptr_i  (alloc_ptr_i),
      .alloc_rdy_o  (alloc_rdy_o),
      .alloc_tag_o  (alloc_tag_o),
      .retire_vld_i (retire_vld_i),
      .flush_rt_i   (flush_rt_i),
      .ras_ptr_rt_o (ras_ptr_rt_o),
      .bob_vld_o    (bob_vld_o),
      .count_o      (count_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [PTR_W-1:0] ap, input logic rv, input logic fl);
      alloc_vld_i  = av;
      alloc_ptr_i  = ap;
      retire_vld_i = rv;
      flush_rt_i   = fl;
   endtask

   task automatic chk_outs(input string tag_s, input logic rdy, input logic [IDX_W-1:0] tag,
                           input logic [PTR_W-1:0] rp, input logic bv, input logic [IDX_W:0] cnt);
      chk({tag_s, ".rdy"}, 32'(alloc_rdy_o), 32'(rdy));
      chk({tag_s, ".tag"}, 32'(alloc_tag_o), 32'(tag));
      chk({tag_s, ".ras_ptr"}, 32'(ras_ptr_rt_o), 32'(rp));
      chk({tag_s, ".bob_vld"}, 32'(bob_vld_o), 32'(bv));
      chk({tag_s, ".count"}, 32'(count_o), 32'(cnt));
   endtask

   task automatic fill_vectors();
      // Columns: alloc_vld, alloc_ptr, retire_vld, flush | rdy, tag, ras_ptr, bob_vld, count
      // Expected outputs are those seen with the inputs applied, before the edge.
      // Fill 1..8, ninth alloc dropped, retire twice.
      vecs[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 1'b0, 4'd0};
      vecs[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 3'd1, 4'h1, 1'b1, 4'd1};
      vecs[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 3'd2, 4'h1, 1'b1, 4'd2};
      vecs[3]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 3'd3, 4'h1, 1'b1, 4'd3};
      vecs[4]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 3'd4, 4'h1, 1'b1, 4'd4};
      vecs[5]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 3'd5, 4'h1, 1'b1, 4'd5};
      vecs[6]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 3'd6, 4'h1, 1'b1, 4'd6};
      vecs[7]  = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 3'd7, 4'h1, 1'b1, 4'd7};
      vecs[8]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 3'd0, 4'h1, 1'b1, 4'd8};
      vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h1, 1'b1, 4'd8};
      vecs[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 4'h2, 1'b1, 4'd7};
      vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'h3, 1'b1, 4'd6};
      // Refill to full, then retire+alloc while full: alloc refused.
      vecs[12] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 3'd0, 4'h3, 1'b1, 4'd6};
      vecs[13] = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 3'd1, 4'h3, 1'b1, 4'd7};
      vecs[14] = '{1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 3'd2, 4'h3, 1'b1, 4'd8};
      vecs[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 4'h4, 1'b1, 4'd7};
      // Alloc+retire together: count unchanged, tag advances.
      vecs[16] = '{1'b1, 4'hD, 1'b1, 1'b0, 1'b1, 3'd2, 4'h4, 1'b1, 4'd7};
      vecs[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd3, 4'h5, 1'b1, 4'd7};
      vecs[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd3, 4'h6, 1'b1, 4'd6};
      vecs[19] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd3, 4'h7, 1'b1, 4'd5};
      vecs[20] = '{1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 3'd3, 4'h8, 1'b1, 4'd4};
      vecs[21] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd4, 4'hA, 1'b1, 4'd4};
      // Flush together with alloc and retire: flush only.
      vecs[22] = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 3'd4, 4'hA, 1'b1, 4'd4};
      vecs[23] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'hA, 1'b0, 4'd0};
      // Flush and retire on an empty queue: no change.
      vecs[24] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 4'hA, 1'b0, 4'd0};
      vecs[25] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'hA, 1'b0, 4'd0};
      vecs[26] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 4'hA, 1'b0, 4'd0};
      vecs[27] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'hA, 1'b0, 4'd0};
      // Allocate 5,6,7, retire once, flush with live entries.
      vecs[28] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 3'd0, 4'hA, 1'b0, 4'd0};
      vecs[29] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 3'd1, 4'h5, 1'b1, 4'd1};
      vecs[30] = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 3'd2, 4'h5, 1'b1, 4'd2};
      vecs[31] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd3, 4'h5, 1'b1, 4'd3};
      vecs[32] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd3, 4'h6, 1'b1, 4'd2};
      vecs[33] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 4'h6, 1'b0, 4'd0};
   endtask

   initial begin
      logic [PTR_W-1:0] p;
      logic [PTR_W-1:0] last;
      checks   = 0;
      failures = 0;
      drive(1'b0, '0, 1'b0, 1'b0);
      fill_vectors();

      // Reset and idle check
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      chk_outs("reset", 1'b1, 3'd0, 4'h0, 1'b0, 4'd0);

      // Vector table
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clock);
         drive(vecs[i].av, vecs[i].ap, vecs[i].rv, vecs[i].fl);
         #1;
         chk_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].tag, vecs[i].rp, vecs[i].bv, vecs[i].cnt);
      end
      @(negedge clock);
      drive(1'b0, '0, 1'b0, 1'b0);

      // Wrap-around: 12 alloc/retire pairs on an empty queue, tag wraps 7 -> 0
      for (int i = 0; i < 12; i++) begin
         p = PTR_W'(4'hF + i);
         @(negedge clock);
         drive(1'b1, p, 1'b0, 1'b0);
         #1;
         chk($sformatf("wrap%0d.tag", i), 32'(alloc_tag_o), 32'(i % DEPTH));
         chk($sformatf("wrap%0d.rdy", i), 32'(alloc_rdy_o), 32'd1);
         exp_q.push_back(p);
         @(negedge clock);
         drive(1'b0, '0, 1'b1, 1'b0);
         #1;
         chk($sformatf("wrap%0d.cnt_le1", i), 32'(count_o <= 1), 32'd1);
         chk($sformatf("wrap%0d.bob", i), 32'(bob_vld_o), 32'd1);
         if (exp_q.size() == 0) begin
            chk($sformatf("wrap%0d.q_empty", i), 32'd0, 32'd1);
         end else begin
            last = exp_q.pop_front();
            chk($sformatf("wrap%0d.ras_ptr", i), 32'(ras_ptr_rt_o), 32'(last));
         end
      end
      @(negedge clock);
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("wrap_end.ras_ptr", 32'(ras_ptr_rt_o), 32'(last));
      chk("wrap_end.count", 32'(count_o), 32'd0);
      chk("wrap_end.tag", 32'(alloc_tag_o), 32'd4);

      // Asynchronous reset mid-operation, away from any clock edge
      @(negedge clock);
      drive(1'b1, 4'h9, 1'b0, 1'b0);
      @(negedge clock);
      drive(1'b1, 4'h3, 1'b0, 1'b0);
      @(negedge clock);
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk_outs("pre_rst", 1'b1, 3'd6, 4'h9, 1'b1, 4'd2);
      #1;
      reset_n = 1'b0;
      #1;
      chk_outs("async_rst", 1'b1, 3'd0, 4'h0, 1'b0, 4'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      chk_outs("post_rst", 1'b1, 3'd0, 4'h0, 1'b0, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ras_rt_ckpt.md
# ras_rt_ckpt

Retire-side checkpoint queue for the fetch return address stack. Each RAS-affecting branch leaving fetch deposits its post-operation stack pointer here, in program order. Branches retire in order and release their entries. When retire flushes on the oldest branch, the block supplies that branch's pointer as the restore value, together with the qualifying valid, back to the fetch RAS.

## Interface
**Parameters**
- `DEPTH`, 8: checkpoint entries; must be a power of two.
- `IDX_W`, 3: log2(`DEPTH`).
- `PTR_W`, 4: RAS pointer width; matches the 16-entry stack.

**Ports**
- `clock` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `alloc_vld_i` in 1: a branch with a non-zero RAS control is leaving fetch.
- `alloc_ptr_i` in `PTR_W`: RAS pointer after that branch's push/pop.
- `alloc_rdy_o` out 1: a free entry exists and no flush is in progress.
- `alloc_tag_o` out `IDX_W`: entry index that the current allocation receives.
- `retire_vld_i` in 1: the oldest checkpointed branch retires without a flush.
- `flush_rt_i` in 1: retire flush on the oldest checkpointed branch.
- `ras_ptr_rt_o` out `PTR_W`: restore pointer for the fetch RAS.
- `bob_vld_o` out 1: `ras_ptr_rt_o` comes from a live checkpoint entry.
- `count_o` out `IDX_W+1`: occupied entries.

## Operation
**Storage**
- `DEPTH` × `PTR_W` register array.
- `head` and `tail` indices, `IDX_W` wide, wrapping modulo `DEPTH`.
- `count`, `IDX_W+1` wide.
- `arch_ptr`, `PTR_W` wide: pointer of the last branch that left the queue.

**Derived flags**
- `empty` = (`count` == 0).
- `full` = (`count` == `DEPTH`).

**Allocate**
- Fires when `alloc_vld_i & alloc_rdy_o`.
- Effect: `mem[tail]` <= `alloc_ptr_i`; `tail` <= `tail`+1; `count` +1.
- `alloc_tag_o` = `tail`, combinational from registered state.
- `alloc_rdy_o` = `~full & ~flush_rt_i`. There is no same-cycle bypass from a retire freeing an entry.
- `alloc_vld_i` while `alloc_rdy_o` is low: the allocation is dropped with no state change. Upstream must hold the request.

**Retire**
- Fires when `retire_vld_i & ~empty & ~flush_rt_i`.
- Effect: `arch_ptr` <= `mem[head]`; `head` <= `head`+1; `count` −1.
- `retire_vld_i` while empty: ignored.

**Flush**
- Fires when `flush_rt_i`.
- If not empty: `arch_ptr` <= `mem[head]`.
- In all cases: `head` <= 0, `tail` <= 0, `count` <= 0. All younger checkpoints are discarded.

**Outputs**
- `ras_ptr_rt_o` = `empty ? arch_ptr : mem[head]`, combinational.
- `bob_vld_o` = `~empty`.
- The fetch RAS uses `flush_rt_i & bob_vld_o` as its flush qualifier. An empty queue therefore leaves the fetch pointer untouched.

**Priority per cycle**
- Flush beats retire and allocate.
- Retire and allocate in the same cycle: both take effect and `count` is unchanged.

**Pointer arithmetic**
- Pointer values are stored verbatim; no arithmetic is applied to them.
- `head` and `tail` wrap naturally at `DEPTH`.

## Timing
- **Reset values:**
  - `head` = `tail` = `count` = 0, `arch_ptr` = 0.
  - `alloc_rdy_o` = 1 (when `flush_rt_i` = 0), `alloc_tag_o` = 0.
  - `ras_ptr_rt_o` = 0, `bob_vld_o` = 0, `count_o` = 0.
  - Array contents are don't-care.
- **Allocate latency:** an entry written at edge N is visible on `ras_ptr_rt_o`/`bob_vld_o` from N+1 when the queue was empty. Retire or flush can act on it from cycle N+1.
- **Flush timing:** takes effect at the edge where `flush_rt_i` is sampled. From the next cycle, `bob_vld_o` = 0 and `ras_ptr_rt_o` = the flushed branch's pointer.
- **Reset asserted mid-operation:** all state clears immediately (asynchronous). Outputs take their reset values without waiting for a clock.
- **Full-queue behaviour:** `alloc_rdy_o` deasserts in the cycle after the `DEPTH`-th allocation. It reasserts in the cycle after the first retire or flush.

## Test plan
1. **Reset check:** assert reset, release, no stimulus -> `alloc_rdy_o`=1, `bob_vld_o`=0, `ras_ptr_rt_o`=0, `count_o`=0.
2. **Fill and drain:**
   - Allocate pointers 1..8 on consecutive cycles -> `alloc_tag_o` steps 0..7, `count_o`=8, `alloc_rdy_o`=0.
   - Then a ninth alloc -> dropped.
   - Then retire twice -> `ras_ptr_rt_o` shows 1, then 2, then 3; `count_o`=6.
3. **Flush with live entries:**
   - Allocate pointers 5, 6, 7; retire once; then `flush_rt_i` -> `ras_ptr_rt_o`=6 before the flush edge.
   - After the flush edge: `bob_vld_o`=0, `ras_ptr_rt_o`=6, `count_o`=0, `alloc_tag_o`=0.
4. **Wrap-around:**
   - Run 12 alloc/retire pairs with pointer values 0xF, 0x0, 0x1, … -> `alloc_tag_o` wraps 7→0.
   - Retired pointers emerge in order and `count_o` never exceeds 1.
5. **Simultaneous events:**
   - Queue full, retire and alloc in the same cycle -> retire occurs, alloc is refused, `count_o`=7.
   - Queue half-full, alloc and retire in the same cycle -> `count_o` unchanged, new tag advances.
   - `flush_rt_i` together with `alloc_vld_i` and `retire_vld_i` -> flush only, `count_o`=0.
6. **Empty-queue events:**
   - `flush_rt_i` on an empty queue -> `bob_vld_o` stays 0 and `arch_ptr` is unchanged.
   - `retire_vld_i` on an empty queue -> no state change.
